// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler slice.
// Provides the ALU control code constants, the legal-op predicate and the
// scheduler FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
      default:                                            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_scheduler_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
// Ports:
//   valid[1:0]  request present per port
//   last_grant  port granted most recently
//   grant       chosen port (meaningful only when any is high)
//   any         at least one request present
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any   = valid[0] | valid[1];
    grant = 1'b0;
    if (valid == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = valid[1];
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one single-cycle ALU between two requesters.
// Grants one operation at a time (round-robin), drives the ALU from latched
// operands for SETTLE_CYCLES cycles, captures the result and returns it with a
// locally computed zero flag over a per-port valid/ready response handshake.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   req_valid_i / req_ready_i    request handshake, port i
//   req_op_i, req_a_i, req_b_i   ALU control code and operands, port i
//   resp_valid_i / resp_ready_i  response handshake, port i
//   resp_data, resp_zero, resp_err  captured result, zero flag, illegal-op flag
//   alu_control, alu_a, alu_b    to the external ALU
//   alu_out                      from the external ALU
//   busy                         FSM not idle
//   op_count                     completed responses (wrapping)
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [3:0]  req_op_0,
  input  logic [3:0]  req_op_1,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_0,
  input  logic [31:0] req_b_1,
  output logic        resp_valid_0,
  output logic        resp_valid_1,
  input  logic        resp_ready_0,
  input  logic        resp_ready_1,
  output logic [31:0] resp_data,
  output logic        resp_zero,
  output logic        resp_err,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  output logic        busy,
  output logic [15:0] op_count
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("alu_scheduler: SETTLE_CYCLES must be within 1..15");
  end

  state_t     state;
  logic       last_grant;
  logic       grant_q;
  logic [3:0] settle_cnt;
  logic       pick_grant;
  logic       pick_any;
  logic       resp_take;

  rr_pick2 u_pick (
    .valid      ({req_valid_1, req_valid_0}),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  // Ready is qualified by the port's own valid so an idle port never sees ready.
  assign req_ready_0 = (state == IDLE) && req_valid_0 && !pick_grant;
  assign req_ready_1 = (state == IDLE) && req_valid_1 &&  pick_grant;
  assign busy        = (state != IDLE);
  assign resp_take   = grant_q ? resp_ready_1 : resp_ready_0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant_q      <= 1'b0;
      settle_cnt   <= '0;
      alu_control  <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      resp_valid_0 <= 1'b0;
      resp_valid_1 <= 1'b0;
      resp_data    <= '0;
      resp_zero    <= 1'b0;
      resp_err     <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q     <= pick_grant;
            last_grant  <= pick_grant;
            alu_control <= pick_grant ? req_op_1 : req_op_0;
            alu_a       <= pick_grant ? req_a_1  : req_a_0;
            alu_b       <= pick_grant ? req_b_1  : req_b_0;
            settle_cnt  <= 4'(SETTLE_CYCLES);
            state       <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == 4'd1) begin
            settle_cnt <= '0;
            if (is_legal_op(alu_control)) begin
              resp_data <= alu_out;
              resp_zero <= (alu_out == '0);
              resp_err  <= 1'b0;
            end else begin
              resp_data <= '0;
              resp_zero <= 1'b1;
              resp_err  <= 1'b1;
            end
            resp_valid_0 <= !grant_q;
            resp_valid_1 <=  grant_q;
            state        <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_take) begin
            resp_valid_0 <= 1'b0;
            resp_valid_1 <= 1'b0;
            op_count     <= op_count + 16'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed testbench for alu_scheduler. The bench plays the external ALU and
// checks against hand-computed expected values. A second instance with
// SETTLE_CYCLES = 3 covers reset during DRIVE.
`timescale 1ns/1ps
module tb_alu_scheduler;

  logic        clock = 1'b0;
  logic        reset, reset_s3;
  logic        req_valid_0, req_valid_1;
  logic [3:0]  req_op_0, req_op_1;
  logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic        resp_ready_0, resp_ready_1;

  logic        req_ready_0, req_ready_1, resp_valid_0, resp_valid_1;
  logic [31:0] resp_data, alu_a, alu_b, alu_out;
  logic        resp_zero, resp_err, busy;
  logic [3:0]  alu_control;
  logic [15:0] op_count;

  logic        req_ready_0_s3, req_ready_1_s3, resp_valid_0_s3, resp_valid_1_s3;
  logic [31:0] resp_data_s3, alu_a_s3, alu_b_s3, alu_out_s3;
  logic        resp_zero_s3, resp_err_s3, busy_s3;
  logic [3:0]  alu_control_s3;
  logic [15:0] op_count_s3;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (a < b) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out    = alu_model(alu_control, alu_a, alu_b);
  assign alu_out_s3 = alu_model(alu_control_s3, alu_a_s3, alu_b_s3);

  alu_scheduler #(.SETTLE_CYCLES(1)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .busy(busy), .op_count(op_count)
  );

  alu_scheduler #(.SETTLE_CYCLES(3)) u_dut_s3 (
    .clock(clock), .reset(reset_s3),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0_s3), .req_ready_1(req_ready_1_s3),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
    .resp_valid_0(resp_valid_0_s3), .resp_valid_1(resp_valid_1_s3),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_data(resp_data_s3), .resp_zero(resp_zero_s3), .resp_err(resp_err_s3),
    .alu_control(alu_control_s3), .alu_a(alu_a_s3), .alu_b(alu_b_s3), .alu_out(alu_out_s3),
    .busy(busy_s3), .op_count(op_count_s3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; reset_s3 = 1'b1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_op_0 = '0; req_op_1 = '0;
    req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;

    // Reset state
    cyc(); cyc(); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_zero", 32'(resp_zero), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_alu_ctl", 32'(alu_control), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_resp_valid", 32'({resp_valid_1, resp_valid_0}), 32'd0);
    check("rst_ready_idle", 32'({req_ready_1, req_ready_0}), 32'd0);
    req_valid_0 = 1'b1; req_op_0 = 4'b0010; req_a_0 = 32'd5; req_b_0 = 32'd7;
    #1 check("rst_ready0_exception", 32'(req_ready_0), 32'd1);

    // ADD 5+7 on port 0; the accept seen during reset must be ignored
    cyc(); reset = 1'b0; #1;
    check("add_accept_ignored", 32'(busy), 32'd0);
    check("add_ready", 32'({req_ready_1, req_ready_0}), 32'b01);
    cyc(); req_valid_0 = 1'b0; #1;
    check("add_drive_ctl", 32'(alu_control), 32'h2);
    check("add_drive_a", alu_a, 32'd5);
    check("add_drive_b", alu_b, 32'd7);
    check("add_no_early_resp", 32'(resp_valid_0), 32'd0);
    cyc(); #1;
    check("add_resp_valid", 32'({resp_valid_1, resp_valid_0}), 32'b01);
    check("add_data", resp_data, 32'd12);
    check("add_zero", 32'(resp_zero), 32'd0);
    check("add_err", 32'(resp_err), 32'd0);
    resp_ready_0 = 1'b1;
    cyc(); resp_ready_0 = 1'b0; #1;
    check("add_op_count", 32'(op_count), 32'd1);
    check("add_idle", 32'({busy, resp_valid_0}), 32'd0);

    // SUB 9-9 on port 1
    req_valid_1 = 1'b1; req_op_1 = 4'b0110; req_a_1 = 32'd9; req_b_1 = 32'd9; #1;
    check("sub_ready", 32'({req_ready_1, req_ready_0}), 32'b10);
    cyc(); req_valid_1 = 1'b0; #1;
    check("sub_drive_ctl", 32'(alu_control), 32'h6);
    cyc(); #1;
    check("sub_resp_valid", 32'({resp_valid_1, resp_valid_0}), 32'b10);
    check("sub_data", resp_data, 32'd0);
    check("sub_zero", 32'(resp_zero), 32'd1);
    resp_ready_1 = 1'b1;
    cyc(); resp_ready_1 = 1'b0; #1;
    check("sub_op_count", 32'(op_count), 32'd2);

    // Both ports continuously valid: grants alternate 0,1,0,1
    req_valid_0 = 1'b1; req_op_0 = 4'b0010; req_a_0 = 32'd1;    req_b_0 = 32'd1;
    req_valid_1 = 1'b1; req_op_1 = 4'b0001; req_a_1 = 32'hF0;   req_b_1 = 32'h0F;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), 32'({req_ready_1, req_ready_0}),
            (k % 2 == 0) ? 32'b01 : 32'b10);
      cyc(); #1;
      check($sformatf("rr_ready_low%0d", k), 32'({req_ready_1, req_ready_0}), 32'd0);
      cyc(); #1;
      check($sformatf("rr_resp%0d", k), 32'({resp_valid_1, resp_valid_0}),
            (k % 2 == 0) ? 32'b01 : 32'b10);
      check($sformatf("rr_data%0d", k), resp_data, (k % 2 == 0) ? 32'd2 : 32'hFF);
      cyc();
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0; resp_ready_0 = 1'b0; resp_ready_1 = 1'b0; #1;
    check("rr_op_count", 32'(op_count), 32'd6);

    // Backpressure on port 0 while port 1 waits
    req_valid_0 = 1'b1; req_op_0 = 4'b0000; req_a_0 = 32'hFF; req_b_0 = 32'h0F; #1;
    check("bp_accept0", 32'(req_ready_0), 32'd1);
    cyc(); req_valid_0 = 1'b0;
    req_valid_1 = 1'b1; req_op_1 = 4'b0110; req_a_1 = 32'd10; req_b_1 = 32'd3; #1;
    check("bp_drive_ready1", 32'(req_ready_1), 32'd0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_valid%0d", i), 32'(resp_valid_0), 32'd1);
      check($sformatf("bp_data%0d", i), resp_data, 32'h0F);
      check($sformatf("bp_flags%0d", i), 32'({resp_err, resp_zero}), 32'd0);
      check($sformatf("bp_ready1_%0d", i), 32'(req_ready_1), 32'd0);
      cyc();
    end
    resp_ready_0 = 1'b1; #1;
    check("bp_hs_ready1", 32'(req_ready_1), 32'd0);
    cyc(); resp_ready_0 = 1'b0; #1;
    check("bp_next_ready1", 32'(req_ready_1), 32'd1);
    check("bp_op_count", 32'(op_count), 32'd7);
    cyc(); req_valid_1 = 1'b0;
    cyc(); #1;
    check("bp_p1_resp", 32'({resp_valid_1, resp_valid_0}), 32'b10);
    check("bp_p1_data", resp_data, 32'd7);
    resp_ready_1 = 1'b1;
    cyc(); resp_ready_1 = 1'b0; #1;
    check("bp_op_count2", 32'(op_count), 32'd8);

    // Illegal op, then SLT 3 < 4
    req_valid_0 = 1'b1; req_op_0 = 4'b0011; req_a_0 = 32'd1; req_b_0 = 32'd2;
    cyc(); req_valid_0 = 1'b0;
    cyc(); #1;
    check("ill_err", 32'(resp_err), 32'd1);
    check("ill_data", resp_data, 32'd0);
    check("ill_zero", 32'(resp_zero), 32'd1);
    resp_ready_0 = 1'b1;
    cyc(); resp_ready_0 = 1'b0;
    req_valid_0 = 1'b1; req_op_0 = 4'b0111; req_a_0 = 32'd3; req_b_0 = 32'd4;
    cyc(); req_valid_0 = 1'b0;
    cyc(); #1;
    check("slt_data", resp_data, 32'd1);
    check("slt_err", 32'(resp_err), 32'd0);
    check("slt_zero", 32'(resp_zero), 32'd0);
    resp_ready_0 = 1'b1;
    cyc(); resp_ready_0 = 1'b0; #1;
    check("slt_op_count", 32'(op_count), 32'd10);
    check("alu_hold_ctl", 32'(alu_control), 32'h7);
    check("alu_hold_a", alu_a, 32'd3);

    // SETTLE_CYCLES = 3 instance: reset during DRIVE drops the operation
    reset = 1'b1; reset_s3 = 1'b0;
    req_valid_0 = 1'b1; req_op_0 = 4'b0010; req_a_0 = 32'd2; req_b_0 = 32'd2; #1;
    check("s3_accept", 32'(req_ready_0_s3), 32'd1);
    cyc(); req_valid_0 = 1'b0; #1;
    check("s3_drive_busy", 32'(busy_s3), 32'd1);
    check("s3_drive_ctl", 32'(alu_control_s3), 32'h2);
    cyc(); reset_s3 = 1'b1;
    cyc(); reset_s3 = 1'b0; #1;
    check("s3_rst_busy", 32'(busy_s3), 32'd0);
    check("s3_rst_ctl", 32'(alu_control_s3), 32'd0);
    check("s3_rst_a", alu_a_s3, 32'd0);
    check("s3_rst_b", alu_b_s3, 32'd0);
    check("s3_rst_op_count", 32'(op_count_s3), 32'd0);
    check("s3_rst_resp", {resp_data_s3[29:0], resp_zero_s3, resp_err_s3}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      check($sformatf("s3_no_resp%0d", i),
            32'({busy_s3, resp_valid_1_s3, resp_valid_0_s3}), 32'd0);
    end
    req_valid_0 = 1'b1; req_valid_1 = 1'b1; #1;
    check("s3_first_grant", 32'({req_ready_1_s3, req_ready_0_s3}), 32'b01);
    cyc(); req_valid_0 = 1'b0; req_valid_1 = 1'b0; #1;
    check("s3_regrant_a", alu_a_s3, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
